// File: rtl/ep_writeback_queue.sv
// Even-pipe writeback queue: buffers results ahead of the register-file write port
// and serves ra/rb forwarding lookups. Optional zero-latency bypass: WB_PASSTHRU_EN.
module ep_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int PKT_W  = 143,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [0:PKT_W-1]          ep_packet_in,
    input  logic                      rf_wr_ready,
    output logic                      rf_wr_en,
    output logic [0:ADDR_W-1]         rf_wr_addr,
    output logic [0:DATA_W-1]         rf_wr_data,
    input  logic [0:ADDR_W-1]         fwd_addr_a,
    output logic                      fwd_hit_a,
    output logic [0:DATA_W-1]         fwd_data_a,
    input  logic [0:ADDR_W-1]         fwd_addr_b,
    output logic                      fwd_hit_b,
    output logic [0:DATA_W-1]         fwd_data_b,
    output logic [0:$clog2(DEPTH)]    count,
    output logic                      overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     cnt;
    logic              ovf;

    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              in_we;
    logic              pass, pop, push, drop;

    // Stage latency and unit id fields are deliberately not extracted.
    assign in_data = ep_packet_in[0:DATA_W-1];
    assign in_addr = ep_packet_in[DATA_W:DATA_W+ADDR_W-1];
    assign in_we   = ep_packet_in[PKT_W-1];

`ifdef WB_PASSTHRU_EN
    assign pass = (cnt == '0) && rf_wr_ready && in_we;
`else
    assign pass = 1'b0;
`endif

    assign pop  = (cnt != '0) && rf_wr_ready;
    assign push = in_we && !pass && ((cnt != FULL) || pop);
    assign drop = in_we && !pass && (cnt == FULL) && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (drop) ovf <= 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes from head/count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[tail] <= in_data;
            mem_addr[tail] <= in_addr;
        end
    end

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (cnt != '0) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = mem_addr[head];
            rf_wr_data = mem_data[head];
        end else if (pass) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = in_addr;
            rf_wr_data = in_data;
        end
    end

    // Walk oldest to youngest so the youngest match overwrites; the
    // incoming packet is newer than anything queued.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        logic [PW-1:0]   idx;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail - PW'(k + 1);
            if ((CW'(k) < cnt) && (mem_addr[idx] == a))
                r = {1'b1, mem_data[idx]};
        end
        if (in_we && (in_addr == a))
            r = {1'b1, in_data};
        return r;
    endfunction

    logic [DATA_W:0] res_a, res_b;
    assign res_a      = lookup(fwd_addr_a);
    assign res_b      = lookup(fwd_addr_b);
    assign fwd_hit_a  = res_a[DATA_W];
    assign fwd_data_a = res_a[DATA_W-1:0];
    assign fwd_hit_b  = res_b[DATA_W];
    assign fwd_data_b = res_b[DATA_W-1:0];

    assign count    = cnt;
    assign overflow = ovf;
endmodule
